// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for the parametrised synchronous FIFO.
// The master side is the producer/consumer (e.g. a bench or a bus agent);
// the slave side is the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              flush;
  logic              clr_err;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels,
// occupancy count, sticky overflow/underflow flags, synchronous flush
// and a choice of registered or first-word-fall-through read data.
// Full/empty come from the registered count, so pointers may simply wrap.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave f
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full, empty;
  logic              wr_acc, rd_acc;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = f.wr_en & ~full  & ~f.flush;
  assign rd_acc = f.rd_en & ~empty & ~f.flush;

  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = (count_q >= AF_C);
  assign f.almost_empty = (count_q <= AE_C);
  assign f.count        = count_q;
  assign f.overflow     = ovf_q;
  assign f.underflow    = udf_q;

  // Next pointers, occupancy and sticky error flags; flush wins over traffic
  // but never touches the error flags, and a new error beats clr_err.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = (f.wr_en & full)  | (ovf_q & ~f.clr_err);
    udf_d    = (f.rd_en & empty) | (udf_q & ~f.clr_err);
    if (f.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= f.wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign f.rd_data = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;

      // Registered read port: updates only on an accepted read, else holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end

      assign f.rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next-generation DUT for the FIFO UVM environment (sequence item, driver, monitor and scoreboard).
- Generalised in data width and depth.
- Adds programmable almost-full/almost-empty thresholds and an occupancy count.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_W, 8: data word width in bits, ≥1.
- DEPTH, 16: number of entries; power of 2, ≥2.
- AF_LVL, 14: almost_full asserts when count ≥ AF_LVL; 1..DEPTH.
- AE_LVL, 2: almost_empty asserts when count ≤ AE_LVL; 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LVL.
- almost_empty  out  1  count ≤ AE_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  clears sticky error flags.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low, on rst_n.
- Reset values:
  - wr_ptr = rd_ptr = count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, rd_data = 0.
  - Memory contents are not reset.
- Write accept: wr_acc = wr_en & ~full & ~flush. On accept, mem[wr_ptr] ← wr_data and wr_ptr ← wr_ptr+1 mod DEPTH.
- Read accept: rd_acc = rd_en & ~empty & ~flush. On accept, rd_ptr ← rd_ptr+1 mod DEPTH.
- Simultaneous read and write:
  - When full: only the read is accepted. The write is rejected and overflow is set.
  - When empty: only the write is accepted and underflow is set. No write-through; the word becomes readable next cycle.
  - Otherwise both are accepted and count is unchanged.
- Count: +1 on write only, −1 on read only, unchanged otherwise. All flags are combinational decodes of the registered count, so they are valid the cycle after the causing edge.
- FWFT=0:
  - rd_data is registered: on rd_acc, rd_data ← mem[rd_ptr], visible the cycle after the rd_en edge.
  - Otherwise rd_data holds its value, including on a rejected read.
- FWFT=1:
  - rd_data = mem[rd_ptr] whenever empty=0; forced to 0 when empty=1.
  - A word written into an empty FIFO appears on rd_data one cycle after the write edge, together with empty deasserting.
  - rd_en acknowledges (pops) the displayed word.
- Pointer wrap: pointers wrap modulo DEPTH; full/empty are unambiguous via count.
- Errors:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both clear on clr_err; if set and clear occur in the same cycle, set wins.
  - Both are evaluated even when flush=1.
- Flush:
  - Takes priority over wr_en/rd_en. wr_ptr, rd_ptr and count go to 0 at the clock edge, giving empty = 1 the next cycle.
  - FWFT=0: rd_data is held. FWFT=1: rd_data reads 0 via empty.
  - Error flags are unaffected.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first write after rst_n deasserts lands at address 0.

Test Plan:
- Fill and drain (DATA_W=8, DEPTH=16, FWFT=0): write 0x00..0x0F, then read 16 times.
  → full=1 at count=16; almost_full from count=14. Reads return 0x00..0x0F in order, each one cycle after rd_en. Final state: empty=1, almost_empty=1 from count ≤ 2.
- Overflow/underflow: 17th write when full → data 0x0F unchanged, count stays 16, overflow=1 sticky. Then pulse clr_err → overflow=0. Read when empty → underflow=1, rd_data held.
- Simultaneous rd/wr at count=8 for 20 cycles → count stays 8, data order preserved across pointer wrap. At count=16 with both asserted → read only, count 15, overflow=1.
- FWFT=1: write 0xA5 to empty → next cycle empty=0, rd_data=0xA5 with no rd_en. Then rd_en=1 → empty=1 and rd_data=0 next cycle.
- Flush at count=5 with wr_en=1 → count=0, empty=1 next cycle, write dropped, overflow/underflow unchanged.
- Assert rst_n=0 asynchronously at count=9 mid-write → all outputs go to reset values without a clock edge. Next write/read after release returns the new data.
